fsic_io_serdes_link_ctrl: RTL and testbench
===========================================

// Module: fsic_io_serdes_link_ctrl
// PURPOSE
// - Brings up the io_serdes link after reset: AXI-Lite master that writes rxen_ctl, waits, writes txen_ctl, then reads back and confirms.
// - Sits between the config controller and the io_serdes AXI-Lite slave port, and drives its cc_is_enable.
// - Reports busy, link_up and error status to firmware-visible logic.
// PARAMETERS
// - pADDR_WIDTH     10  DW address width; the master addresses [pADDR_WIDTH+1:2].
// - pDATA_WIDTH     32  AXI-Lite data width.
// - pRX_TO_TX_DLY   16  axi_clk cycles between the rxen write completing and the txen write being issued (>=1).
// - pHS_TIMEOUT     255 Max cycles to wait for any ready/valid from the slave before erroring (>=1).
// - pRETRY          3   Readback attempts before err_readback (>=1).
// PORTS
// - axi_clk      in   1                 Single clock.
// - axi_reset_n  in   1                 Asynchronous active-low reset.
// - start        in   1                 Pulse; begins bring-up from IDLE or ERR, ignored otherwise.
// - cc_is_enable out  1                 High only while an AXI-Lite transaction is outstanding.
// - m_awvalid    out  1                 Write address valid.
// - m_awaddr     out  pADDR_WIDTH       Write DW address, always 0.
// - m_awready    in   1                 Write address ready.
// - m_wvalid     out  1                 Write data valid.
// - m_wdata      out  pDATA_WIDTH       Write data.
// - m_wstrb      out  pDATA_WIDTH/8     Write strobe, always 4'b0001.
// - m_wready     in   1                 Write data ready.
// - m_arvalid    out  1                 Read address valid.
// - m_araddr     out  pADDR_WIDTH       Read DW address, always 0.
// - m_arready    in   1                 Read address ready.
// - m_rvalid     in   1                 Read data valid.
// - m_rdata      in   pDATA_WIDTH       Read data.
// - m_rready     out  1                 Read data ready.
// - busy         out  1                 State is not IDLE, UP or ERR.
// - link_up      out  1                 Bring-up confirmed (state UP).
// - err_timeout  out  1                 Sticky; a handshake timeout occurred.
// - err_readback out  1                 Sticky; readback failed pRETRY times.
// - state_out    out  3                 Current FSM state encoding.
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all counters 0. A mid-operation reset aborts with no further bus activity.
// - States (state_out encoding):
//   - IDLE=0: wait for start.
//   - WR_RX=1: write m_wdata=32'h1.
//   - DLY=2: count pRX_TO_TX_DLY cycles.
//   - WR_TX=3: write m_wdata=32'h3.
//   - RD=4: read address 0.
//   - UP=5: link confirmed.
//   - ERR=6: error hold.
// - Start latency: start sampled high in IDLE/ERR at edge N gives state WR_RX, with m_awvalid=m_wvalid=1 after edge N.
//   - Start from ERR clears both error flags.
// - Writes: m_awvalid and m_wvalid assert together.
//   - Each deasserts the cycle after its own ready is sampled high.
//   - The write completes when both have been accepted, in the same or different cycles.
//   - Exactly one transfer per channel; no valid is ever reasserted.
// - Reads:
//   - m_arvalid is held until m_arready is sampled high.
//   - m_rready is then 1 until m_rvalid is sampled high, and m_rdata is captured on that edge.
//   - Reads do not overlap writes.
// - cc_is_enable = any of m_awvalid, m_wvalid, m_arvalid or m_rready.
// - Timeout: the counter clears on entering each wait and increments each cycle without the awaited handshake.
//   - Reaching pHS_TIMEOUT gives state ERR, err_timeout=1, and drops all valids/ready on the next edge.
// - DLY: state exits to WR_TX on the cycle the counter equals pRX_TO_TX_DLY-1.
// - Readback:
//   - m_rdata[1:0]==2'b11 gives state UP.
//   - Otherwise the retry counter increments and a new read is issued the next cycle.
//   - After pRETRY failures: state ERR, err_readback=1.
// - UP and ERR are sticky until reset; start is honoured in ERR only.
// - Simultaneous ready and timeout expiry on the same edge: the handshake wins.
// TESTING
// - Ready/rvalid tied 1, rdata=3, start pulse:
//   - wdata 1 written at cycle 1.
//   - 16 DLY cycles, then wdata 3 written.
//   - One read, then link_up=1 with busy=0.
// - m_awready one cycle after m_wready: one aw and one w transfer, no duplicate; FSM advances once both are accepted.
// - m_awready held 0: err_timeout=1 and state ERR after 255 cycles; cc_is_enable=0 on the next cycle.
// - rdata=32'h1 on every read: 3 reads issued, then err_readback=1 and state ERR; a start then clears the errors and restarts at WR_RX.
// - Reset asserted during DLY: all outputs 0 immediately, state IDLE; a new start repeats the full sequence.
// - start pulsed in WR_TX and in UP: no effect on sequence or outputs.

Source files
------------

// File: rtl/fsic_io_serdes_link_ctrl_if.sv
// rtl/fsic_io_serdes_link_ctrl_if.sv - AXI-Lite bundle between the link controller and the io_serdes slave port
interface fsic_io_serdes_link_ctrl_if #(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32
);
  logic                     awvalid;
  logic [pADDR_WIDTH-1:0]   awaddr;
  logic                     awready;
  logic                     wvalid;
  logic [pDATA_WIDTH-1:0]   wdata;
  logic [pDATA_WIDTH/8-1:0] wstrb;
  logic                     wready;
  logic                     arvalid;
  logic [pADDR_WIDTH-1:0]   araddr;
  logic                     arready;
  logic                     rvalid;
  logic [pDATA_WIDTH-1:0]   rdata;
  logic                     rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fsic_io_serdes_link_ctrl.sv
// rtl/fsic_io_serdes_link_ctrl.sv - io_serdes link bring-up sequencer (rxen write, delay, txen write, readback)
module fsic_io_serdes_link_ctrl #(
  parameter int pADDR_WIDTH   = 10,
  parameter int pDATA_WIDTH   = 32,
  parameter int pRX_TO_TX_DLY = 16,
  parameter int pHS_TIMEOUT   = 255,
  parameter int pRETRY        = 3
) (
  input  logic                              axi_clk,
  input  logic                              axi_reset_n,
  input  logic                              start,
  output logic                              cc_is_enable,
  fsic_io_serdes_link_ctrl_if.master        m,
  output logic                              busy,
  output logic                              link_up,
  output logic                              err_timeout,
  output logic                              err_readback,
  output logic [2:0]                        state_out
);

  localparam int TO_W  = $clog2(pHS_TIMEOUT + 1);
  localparam int DLY_W = $clog2(pRX_TO_TX_DLY + 1);
  localparam int RT_W  = $clog2(pRETRY + 1);

  localparam logic [TO_W-1:0]          TO_LAST   = TO_W'(pHS_TIMEOUT - 1);
  localparam logic [DLY_W-1:0]         DLY_LAST  = DLY_W'(pRX_TO_TX_DLY - 1);
  localparam logic [RT_W-1:0]          RT_LAST   = RT_W'(pRETRY - 1);
  localparam logic [pADDR_WIDTH-1:0]   ADDR_ZERO = '0;
  localparam logic [pDATA_WIDTH-1:0]   RXEN_VAL  = pDATA_WIDTH'(32'h1);
  localparam logic [pDATA_WIDTH-1:0]   TXEN_VAL  = pDATA_WIDTH'(32'h3);
  localparam logic [pDATA_WIDTH/8-1:0] STRB_LO   = (pDATA_WIDTH/8)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_RX = 3'd1,
    S_DLY   = 3'd2,
    S_WR_TX = 3'd3,
    S_RD    = 3'd4,
    S_UP    = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [RT_W-1:0]    retry_q, retry_d;
  logic               err_to_q, err_to_d;
  logic               err_rb_q, err_rb_d;
  logic               wait_miss;
  logic               unused_rdata_hi;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      to_cnt_q  <= '0;
      dly_cnt_q <= '0;
      retry_q   <= '0;
      err_to_q  <= 1'b0;
      err_rb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      to_cnt_q  <= to_cnt_d;
      dly_cnt_q <= dly_cnt_d;
      retry_q   <= retry_d;
      err_to_q  <= err_to_d;
      err_rb_q  <= err_rb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    to_cnt_d  = to_cnt_q;
    dly_cnt_d = dly_cnt_q;
    retry_d   = retry_q;
    err_to_d  = err_to_q;
    err_rb_d  = err_rb_q;
    wait_miss = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d   = S_WR_RX;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          to_cnt_d  = '0;
          retry_d   = '0;
          err_to_d  = 1'b0;
          err_rb_d  = 1'b0;
        end
      end
      S_WR_RX, S_WR_TX: begin
        // Each channel drops independently once accepted; the write is done when both are gone.
        awvalid_d = awvalid_q & ~m.awready;
        wvalid_d  = wvalid_q & ~m.wready;
        if (!awvalid_d && !wvalid_d) begin
          to_cnt_d = '0;
          if (state_q == S_WR_RX) begin
            state_d   = S_DLY;
            dly_cnt_d = '0;
          end else begin
            state_d   = S_RD;
            arvalid_d = 1'b1;
          end
        end else begin
          wait_miss = 1'b1;
        end
      end
      S_DLY: begin
        if (dly_cnt_q == DLY_LAST) begin
          state_d   = S_WR_TX;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          to_cnt_d  = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      S_RD: begin
        if (arvalid_q) begin
          if (m.arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            to_cnt_d  = '0;
          end else begin
            wait_miss = 1'b1;
          end
        end else if (rready_q) begin
          if (m.rvalid) begin
            rready_d = 1'b0;
            to_cnt_d = '0;
            if (m.rdata[1:0] == 2'b11) begin
              state_d = S_UP;
            end else if (retry_q == RT_LAST) begin
              state_d  = S_ERR;
              err_rb_d = 1'b1;
            end else begin
              retry_d   = retry_q + RT_W'(1);
              arvalid_d = 1'b1;
            end
          end else begin
            wait_miss = 1'b1;
          end
        end
      end
      S_UP: begin
      end
      default: state_d = S_IDLE;
    endcase

    // A handshake on the expiry edge was already taken above, so it beats the timeout.
    if (wait_miss) begin
      if (to_cnt_q == TO_LAST) begin
        state_d   = S_ERR;
        err_to_d  = 1'b1;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  assign unused_rdata_hi = ^m.rdata[pDATA_WIDTH-1:2];

  assign m.awvalid = awvalid_q;
  assign m.awaddr  = ADDR_ZERO;
  assign m.wvalid  = wvalid_q;
  assign m.wdata   = !wvalid_q ? '0 : ((state_q == S_WR_TX) ? TXEN_VAL : RXEN_VAL);
  assign m.wstrb   = wvalid_q ? STRB_LO : '0;
  assign m.arvalid = arvalid_q;
  assign m.araddr  = ADDR_ZERO;
  assign m.rready  = rready_q;

  assign cc_is_enable = awvalid_q | wvalid_q | arvalid_q | rready_q;
  assign busy         = (state_q == S_WR_RX) || (state_q == S_DLY) ||
                        (state_q == S_WR_TX) || (state_q == S_RD);
  assign link_up      = (state_q == S_UP);
  assign err_timeout  = err_to_q;
  assign err_readback = err_rb_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_fsic_io_serdes_link_ctrl.sv
// tb/tb_fsic_io_serdes_link_ctrl.sv - directed and randomized bring-up checks against a transaction-level model
module tb_fsic_io_serdes_link_ctrl;
  localparam int DLY   = 16;
  localparam int TO    = 255;
  localparam int RETRY = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cc, busy, link_up, err_to, err_rb;
  logic [2:0] st;

  fsic_io_serdes_link_ctrl_if #(.pADDR_WIDTH(10), .pDATA_WIDTH(32)) bus ();

  fsic_io_serdes_link_ctrl #(
    .pADDR_WIDTH(10), .pDATA_WIDTH(32), .pRX_TO_TX_DLY(DLY),
    .pHS_TIMEOUT(TO), .pRETRY(RETRY)
  ) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .start(start), .cc_is_enable(cc),
    .m(bus), .busy(busy), .link_up(link_up), .err_timeout(err_to),
    .err_readback(err_rb), .state_out(st)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int unsigned pct_aw = 100, pct_w = 100, pct_ar = 100, pct_r = 100;
  logic [31:0] rd_vals[$];
  int rd_idx = 0;
  int aw_cyc[$], w_cyc[$], ar_cyc[$], r_cyc[$];
  logic [31:0] w_data[$];
  int rule_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave responder and transfer log: inputs change at the falling edge, handshakes land on the next rising edge.
  always @(negedge clk) begin
    bus.awready = ($urandom_range(99) < pct_aw);
    bus.wready  = ($urandom_range(99) < pct_w);
    bus.arready = ($urandom_range(99) < pct_ar);
    bus.rvalid  = ($urandom_range(99) < pct_r);
    bus.rdata   = (rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : 32'h1;
    #1;
    if (bus.awvalid && bus.awready) begin
      aw_cyc.push_back(cyc + 1);
      if (bus.awaddr !== 10'd0) rule_bad++;
    end
    if (bus.wvalid && bus.wready) begin
      w_cyc.push_back(cyc + 1);
      w_data.push_back(bus.wdata);
      if (bus.wstrb !== 4'b0001) rule_bad++;
    end
    if (bus.arvalid && bus.arready) begin
      ar_cyc.push_back(cyc + 1);
      if (bus.araddr !== 10'd0) rule_bad++;
    end
    if (bus.rready && bus.rvalid) begin
      r_cyc.push_back(cyc + 1);
      rd_idx++;
    end
    if (rst_n) begin
      if (cc !== (bus.awvalid | bus.wvalid | bus.arvalid | bus.rready)) rule_bad++;
      if (busy !== (st >= 3'd1 && st <= 3'd4)) rule_bad++;
      if (link_up !== (st == 3'd5)) rule_bad++;
      if (bus.arvalid && (bus.awvalid || bus.wvalid)) rule_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_log();
    aw_cyc.delete(); w_cyc.delete(); ar_cyc.delete(); r_cyc.delete();
    w_data.delete();
    rd_idx = 0;
    rule_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!(st == 3'd5 || st == 3'd6) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_in_budget"}, (st == 3'd5 || st == 3'd6), 1);
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (st !== want && n < budget) begin
      step();
      n++;
    end
    check({tag, "_reached"}, st, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dummy, exp_reads, rx_done, tx_first;
    bit exp_up;
    logic [31:0] v;

    // Directed: everything tied ready, good readback
    pct_aw = 100; pct_w = 100; pct_ar = 100; pct_r = 100;
    do_reset();
    check("reset_outputs", {cc, busy, link_up, err_to, err_rb, st, bus.awvalid,
                            bus.wvalid, bus.arvalid, bus.rready}, 0);
    check("reset_wdata", {bus.wdata, bus.wstrb}, 0);
    clear_log();
    rd_vals = '{32'h3};
    pulse_start(s);
    check("start_state", st, 1);
    check("start_valids", {bus.awvalid, bus.wvalid, busy}, 3'b111);
    check("wdata_rx", bus.wdata, 32'h1);
    wait_state(3'd3, 40, "tied_wr_tx");
    check("wdata_tx", bus.wdata, 32'h3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100, "tied");
    check("tied_up", {st, link_up, busy, err_to, err_rb}, {3'd5, 4'b1000});
    check("tied_aw_n", aw_cyc.size(), 2);
    check("tied_w_n", w_cyc.size(), 2);
    check("tied_ar_n", ar_cyc.size(), 1);
    check("tied_r_n", r_cyc.size(), 1);
    if (w_cyc.size() == 2 && ar_cyc.size() == 1 && r_cyc.size() == 1) begin
      check("tied_w0_data", w_data[0], 32'h1);
      check("tied_w1_data", w_data[1], 32'h3);
      check("tied_w0_cyc", w_cyc[0], s + 1);
      check("tied_w1_cyc", w_cyc[1], s + 1 + DLY + 1);
      check("tied_ar_cyc", ar_cyc[0], s + DLY + 3);
      check("tied_r_cyc", r_cyc[0], s + DLY + 4);
    end
    pulse_start(dummy);
    step(); step();
    check("up_ignores_start", {st, link_up, cc}, {3'd5, 2'b10});
    check("up_no_new_aw", aw_cyc.size(), 2);
    check("tied_rules", rule_bad, 0);

    // Directed: aw accepted one cycle after w
    do_reset();
    clear_log();
    rd_vals = '{32'h3};
    pct_aw = 0;
    pulse_start(s);
    pct_aw = 100;
    step();
    check("split_mid", {st, bus.awvalid, bus.wvalid}, {3'd1, 2'b10});
    step();
    check("split_dly", st, 2);
    wait_done(100, "split");
    check("split_up", st, 5);
    check("split_aw_n", aw_cyc.size(), 2);
    check("split_w_n", w_cyc.size(), 2);
    if (aw_cyc.size() == 2 && w_cyc.size() == 2) begin
      check("split_w0_cyc", w_cyc[0], s + 1);
      check("split_aw0_cyc", aw_cyc[0], s + 2);
    end
    check("split_rules", rule_bad, 0);

    // Directed: awready never comes
    do_reset();
    clear_log();
    pct_aw = 0;
    pulse_start(s);
    while (cyc < s + TO - 1) step();
    check("to_before", {st, cc, err_to}, {3'd1, 2'b10});
    step();
    check("to_after", {st, cc, busy, err_to, err_rb}, {3'd6, 4'b0010});
    check("to_aw_n", aw_cyc.size(), 0);
    check("to_w_n", w_cyc.size(), 1);
    pct_aw = 100;

    // Directed: readback never good
    do_reset();
    clear_log();
    rd_vals = '{32'h1, 32'h1, 32'h1, 32'h1};
    pulse_start(s);
    wait_done(200, "rb");
    check("rb_err", {st, err_rb, err_to, link_up}, {3'd6, 3'b100});
    check("rb_ar_n", ar_cyc.size(), RETRY);
    check("rb_r_n", r_cyc.size(), RETRY);
    pulse_start(s);
    check("rb_restart", {st, err_rb, err_to, busy}, {3'd1, 3'b001});
    check("rb_rules", rule_bad, 0);

    // Directed: reset in the middle of DLY
    do_reset();
    clear_log();
    rd_vals = '{32'h3};
    pulse_start(s);
    wait_state(3'd2, 20, "mid_dly");
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {cc, busy, link_up, err_to, err_rb, st, bus.awvalid,
                             bus.wvalid, bus.arvalid, bus.rready}, 0);
    check("midrst_wdata", {bus.wdata, bus.wstrb}, 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_idle", st, 0);
    clear_log();
    pulse_start(s);
    wait_done(100, "midrst");
    check("midrst_up", st, 5);
    check("midrst_w_n", w_cyc.size(), 2);
    if (w_cyc.size() == 2) begin
      check("midrst_data", {w_data[0], w_data[1]}, {32'h1, 32'h3});
      check("midrst_gap", w_cyc[1] - w_cyc[0], DLY + 1);
    end

    // Randomized: random ready latencies and readback values against the model
    for (int it = 0; it < 10; it++) begin
      do_reset();
      clear_log();
      pct_aw = $urandom_range(100, 25);
      pct_w  = $urandom_range(100, 25);
      pct_ar = $urandom_range(100, 25);
      pct_r  = $urandom_range(100, 25);
      rd_vals.delete();
      for (int i = 0; i < RETRY + 1; i++) begin
        v = $urandom;
        if ($urandom_range(1) == 1) v[1:0] = 2'b11;
        else if (v[1:0] == 2'b11) v[0] = 1'b0;
        rd_vals.push_back(v);
      end
      exp_up = 1'b0;
      exp_reads = RETRY;
      for (int i = 0; i < RETRY; i++) begin
        v = rd_vals[i];
        if (!exp_up && v[1:0] == 2'b11) begin
          exp_up = 1'b1;
          exp_reads = i + 1;
        end
      end
      pulse_start(s);
      wait_done(3000, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_state", it), st, exp_up ? 3'd5 : 3'd6);
      check($sformatf("rnd%0d_flags", it), {link_up, err_rb, err_to, busy}, {exp_up, !exp_up, 2'b00});
      check($sformatf("rnd%0d_aw_n", it), aw_cyc.size(), 2);
      check($sformatf("rnd%0d_w_n", it), w_cyc.size(), 2);
      check($sformatf("rnd%0d_ar_n", it), ar_cyc.size(), exp_reads);
      check($sformatf("rnd%0d_r_n", it), r_cyc.size(), exp_reads);
      if (aw_cyc.size() == 2 && w_cyc.size() == 2) begin
        check($sformatf("rnd%0d_wdata", it), {w_data[0], w_data[1]}, {32'h1, 32'h3});
        rx_done  = (aw_cyc[0] > w_cyc[0]) ? aw_cyc[0] : w_cyc[0];
        tx_first = (aw_cyc[1] < w_cyc[1]) ? aw_cyc[1] : w_cyc[1];
        check($sformatf("rnd%0d_dly", it), tx_first >= rx_done + DLY + 1, 1);
      end
      check($sformatf("rnd%0d_rules", it), rule_bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
